posit_add_arbiter: RTL and testbench



---
 rtl/posit_add_arbiter.sv | 106 ++++++++++
 tb/tb_posit_add_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_add_arbiter.sv
// Two-requester front end for a shared, fixed-latency posit adder.
// One operation in flight: IDLE grants and launches, EXEC waits LAT cycles, RESP holds the result.
module posit_add_arbiter #(
    parameter int N   = 8,
    parameter int ES  = 3,
    parameter int RS  = $clog2(N),
    parameter int LAT = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [N-1:0]     req0_a,
    input  logic [N-1:0]     req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [N-1:0]     req1_a,
    input  logic [N-1:0]     req1_b,
    output logic [N-1:0]     add_in1,
    output logic [N-1:0]     add_in2,
    input  logic [ES+RS:0]   add_le,
    input  logic [ES-1:0]    add_e,
    input  logic [RS:0]      add_r,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [ES+RS:0]   rsp_le,
    output logic [ES-1:0]    rsp_e,
    output logic [RS:0]      rsp_r,
    output logic             busy
);

    localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
    } ops_t;

    state_t     state, state_nx;
    logic       ptr;
    logic [3:0] cnt;
    logic       any_vld, gnt, accept;
    ops_t       req_ops [2];
    ops_t       gnt_ops;

    assign req_ops[0] = {req0_a, req0_b};
    assign req_ops[1] = {req1_a, req1_b};

    always_comb begin
        any_vld    = req0_valid | req1_valid;
        // Contention goes to the pointer; otherwise whoever is asking.
        gnt        = (req0_valid && req1_valid) ? ptr : req1_valid;
        gnt_ops    = req_ops[gnt];
        req0_ready = (state == IDLE) && !reset && any_vld && !gnt;
        req1_ready = (state == IDLE) && !reset && any_vld && gnt;
        accept     = req0_ready | req1_ready;
        rsp_valid  = (state == RESP) && !reset;
        busy       = (state != IDLE) && !reset;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = EXEC;
            EXEC:    if (cnt == 4'd0) state_nx = RESP;
            RESP:    if (rsp_valid && rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= 1'b0;
            cnt     <= 4'd0;
            add_in1 <= '0;
            add_in2 <= '0;
            rsp_id  <= 1'b0;
            rsp_le  <= '0;
            rsp_e   <= '0;
            rsp_r   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                ptr     <= ~gnt;
                add_in1 <= gnt_ops.a;
                add_in2 <= gnt_ops.b;
                rsp_id  <= gnt;
                cnt     <= CNT_LOAD;
            end
            if (state == EXEC) begin
                if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    rsp_le <= add_le;
                    rsp_e  <= add_e;
                    rsp_r  <= add_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_posit_add_arbiter.sv
// Bench for posit_add_arbiter: directed scenarios plus a randomized run against a timestamp model.
// A second instance built with LAT=1 shares the inputs and is only inspected by test_lat1.
module tb_posit_add_arbiter;

    localparam int N = 8, ES = 3, RS = 3, LAT = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          req0_valid, req1_valid, rsp_ready;
    logic [N-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic          req0_ready, req1_ready, rsp_valid, rsp_id, busy;
    logic [N-1:0]  add_in1, add_in2;
    logic [ES+RS:0] add_le, rsp_le;
    logic [ES-1:0] add_e, rsp_e;
    logic [RS:0]   add_r, rsp_r;
    logic          d1_r0, d1_r1, d1_rv, d1_id, d1_busy;
    logic [N-1:0]  d1_in1, d1_in2;
    logic [ES+RS:0] d1_le;
    logic [ES-1:0] d1_e;
    logic [RS:0]   d1_r;
    logic          stub_fixed;
    int            tests = 0, fails = 0;

    always #5 clock = ~clock;

    posit_add_arbiter #(.N(N), .ES(ES), .RS(RS), .LAT(LAT)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .add_in1(add_in1), .add_in2(add_in2), .add_le(add_le), .add_e(add_e), .add_r(add_r),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_le(rsp_le), .rsp_e(rsp_e), .rsp_r(rsp_r), .busy(busy));

    posit_add_arbiter #(.N(N), .ES(ES), .RS(RS), .LAT(1)) dut1 (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(d1_r0), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(d1_r1), .req1_a(req1_a), .req1_b(req1_b),
        .add_in1(d1_in1), .add_in2(d1_in2), .add_le(add_le), .add_e(add_e), .add_r(add_r),
        .rsp_valid(d1_rv), .rsp_ready(rsp_ready), .rsp_id(d1_id),
        .rsp_le(d1_le), .rsp_e(d1_e), .rsp_r(d1_r), .busy(d1_busy));

    // Adder stand-in: an arbitrary pure function of the operands it is presented with.
    function automatic logic [ES+RS:0] ref_le(logic [N-1:0] a, logic [N-1:0] b);
        return 7'(a + b);
    endfunction
    function automatic logic [ES-1:0] ref_e(logic [N-1:0] a, logic [N-1:0] b);
        return a[2:0] ^ b[7:5];
    endfunction
    function automatic logic [RS:0] ref_r(logic [N-1:0] a, logic [N-1:0] b);
        return 4'(a ^ b);
    endfunction

    always_comb begin
        if (stub_fixed) begin
            add_le = 7'd5;
            add_e  = 3'd3;
            add_r  = 4'd0;
        end else begin
            add_le = ref_le(add_in1, add_in2);
            add_e  = ref_e(add_in1, add_in2);
            add_r  = ref_r(add_in1, add_in2);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready = 1'b1;
        tick();
        tick();
        @(negedge clock);
        tests++; if (req0_ready !== 1'b0) begin fails++; $display("FAIL reset_req0_ready got=%b exp=0", req0_ready); end
        tests++; if (req1_ready !== 1'b0) begin fails++; $display("FAIL reset_req1_ready got=%b exp=0", req1_ready); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests++; if ({add_in1, add_in2} !== 16'h0) begin fails++; $display("FAIL reset_add_in got=%h exp=0", {add_in1, add_in2}); end
        tests++; if ({rsp_id, rsp_le, rsp_e, rsp_r} !== 15'h0) begin fails++; $display("FAIL reset_rsp got=%h exp=0", {rsp_id, rsp_le, rsp_e, rsp_r}); end
        tick();
        do_reset();
    endtask

    // Single request, then a stalled response and release.
    task automatic test_single_hold();
        do_reset();
        stub_fixed = 1'b1;
        req0_valid = 1'b1; req0_a = 8'h40; req0_b = 8'h20;
        @(negedge clock);
        tests++; if ({req0_ready, req1_ready} !== 2'b10) begin fails++; $display("FAIL single_ready got=%b exp=10", {req0_ready, req1_ready}); end
        tick();
        req0_valid = 1'b0;
        @(negedge clock);
        tests++; if ({add_in1, add_in2} !== 16'h4020) begin fails++; $display("FAIL single_add_in got=%h exp=4020", {add_in1, add_in2}); end
        tests++; if ({busy, rsp_valid} !== 2'b10) begin fails++; $display("FAIL single_c1 busy/rv got=%b exp=10", {busy, rsp_valid}); end
        tick();
        @(negedge clock);
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL single_c2_rv got=%b exp=0", rsp_valid); end
        tick();
        req1_valid = 1'b1; req1_a = 8'h11; req1_b = 8'h22;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            tests++;
            if ({rsp_valid, rsp_id, rsp_le, rsp_e, rsp_r, req0_ready, req1_ready, busy, add_in1, add_in2}
                !== {1'b1, 1'b0, 7'd5, 3'd3, 4'd0, 1'b0, 1'b0, 1'b1, 8'h40, 8'h20}) begin
                fails++;
                $display("FAIL hold_c%0d got rv=%b id=%b le=%0d e=%0d r=%0d rdy=%b%b busy=%b in=%h%h exp rv=1 id=0 le=5 e=3 r=0 rdy=00 busy=1 in=4020",
                         c, rsp_valid, rsp_id, rsp_le, rsp_e, rsp_r, req0_ready, req1_ready, busy, add_in1, add_in2);
            end
            tick();
        end
        rsp_ready = 1'b1;
        req1_valid = 1'b0;
        @(negedge clock);
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL release_rv got=%b exp=1", rsp_valid); end
        tick();
        rsp_ready = 1'b0;
        @(negedge clock);
        tests++; if ({busy, rsp_valid} !== 2'b00) begin fails++; $display("FAIL release_idle busy/rv got=%b exp=00", {busy, rsp_valid}); end
        tests++; if ({add_in1, add_in2} !== 16'h4020) begin fails++; $display("FAIL idle_retain got=%h exp=4020", {add_in1, add_in2}); end
        stub_fixed = 1'b0;
    endtask

    task automatic test_both();
        logic [N-1:0] a0, b0, a1, b1;
        do_reset();
        a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
        req0_valid = 1'b1; req0_a = a0; req0_b = b0;
        req1_valid = 1'b1; req1_a = a1; req1_b = b1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            case (c)
                0: begin tests++; if ({req0_ready, req1_ready} !== 2'b10) begin fails++; $display("FAIL both_c0_ready got=%b exp=10", {req0_ready, req1_ready}); end end
                2: begin tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL both_c2_rv got=%b exp=0", rsp_valid); end end
                3: begin tests++; if ({rsp_valid, rsp_id, rsp_le} !== {1'b1, 1'b0, ref_le(a0, b0)}) begin fails++; $display("FAIL both_c3_rsp got=%b/%b/%h exp=1/0/%h", rsp_valid, rsp_id, rsp_le, ref_le(a0, b0)); end end
                4: begin tests++; if ({req0_ready, req1_ready} !== 2'b01) begin fails++; $display("FAIL both_c4_ready got=%b exp=01", {req0_ready, req1_ready}); end end
                7: begin
                    tests++; if ({rsp_valid, rsp_id, rsp_le, rsp_e, rsp_r} !== {1'b1, 1'b1, ref_le(a1, b1), ref_e(a1, b1), ref_r(a1, b1)}) begin fails++; $display("FAIL both_c7_rsp got=%b/%b/%h/%h/%h exp id=1", rsp_valid, rsp_id, rsp_le, rsp_e, rsp_r); end
                    req0_valid = 1'b0; req1_valid = 1'b0;
                end
                default: ;
            endcase
            tick();
        end
    endtask

    task automatic test_reset_exec();
        do_reset();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 8'h5a; req0_b = 8'ha5;
        tick();
        req0_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        tests++; if ({busy, rsp_valid, add_in1, add_in2} !== 18'h0) begin fails++; $display("FAIL rst_exec got busy=%b rv=%b in=%h%h exp all 0", busy, rsp_valid, add_in1, add_in2); end
        for (int c = 0; c < 6; c++) begin
            tick();
            @(negedge clock);
            tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_exec_norsp_c%0d got=%b exp=0", c, rsp_valid); end
        end
        tick();
    endtask

    task automatic test_req1_only();
        do_reset();
        rsp_ready = 1'b1;
        req1_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            req1_a = 8'($urandom); req1_b = 8'($urandom);
            @(negedge clock);
            tests++;
            if ({req0_ready, req1_ready} !== {1'b0, (c % 4) == 0}) begin
                fails++; $display("FAIL req1_only_c%0d ready got=%b exp=%b", c, {req0_ready, req1_ready}, {1'b0, (c % 4) == 0});
            end
            tick();
        end
        req0_valid = 1'b1;
        @(negedge clock);
        tests++; if ({req0_ready, req1_ready} !== 2'b10) begin fails++; $display("FAIL req1_only_ptr got=%b exp=10", {req0_ready, req1_ready}); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_lat1();
        do_reset();
        stub_fixed = 1'b1;
        req0_valid = 1'b1; req0_a = 8'h33; req0_b = 8'h44;
        @(negedge clock);
        tests++; if (d1_r0 !== 1'b1) begin fails++; $display("FAIL lat1_ready got=%b exp=1", d1_r0); end
        tick();
        req0_valid = 1'b0;
        @(negedge clock);
        tests++; if (d1_rv !== 1'b0) begin fails++; $display("FAIL lat1_c1_rv got=%b exp=0", d1_rv); end
        tick();
        @(negedge clock);
        tests++; if ({d1_rv, d1_id, d1_le} !== {1'b1, 1'b0, 7'd5}) begin fails++; $display("FAIL lat1_c2_rsp got=%b/%b/%0d exp=1/0/5", d1_rv, d1_id, d1_le); end
        stub_fixed = 1'b0;
        do_reset();
    endtask

    // Model: grant by rule, response due LAT+1 cycles after accept, busy until handshake.
    task automatic test_random();
        bit           m_busy = 0, m_ptr = 0, m_id = 0, g, e_r0, e_r1, e_rv, e_busy;
        logic [N-1:0] m_a = '0, m_b = '0;
        int           cyc = 0, rsp_from = 0;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            reset      = ($urandom_range(0, 99) < 2);
            req0_valid = ($urandom_range(0, 9) < 6);
            req1_valid = ($urandom_range(0, 9) < 6);
            req0_a = 8'($urandom); req0_b = 8'($urandom);
            req1_a = 8'($urandom); req1_b = 8'($urandom);
            rsp_ready  = $urandom_range(0, 1);
            g = (req0_valid && req1_valid) ? m_ptr : req1_valid;
            e_r0 = !reset && !m_busy && (req0_valid || req1_valid) && !g;
            e_r1 = !reset && !m_busy && (req0_valid || req1_valid) && g;
            e_rv = !reset && m_busy && (cyc >= rsp_from);
            e_busy = !reset && m_busy;
            @(negedge clock);
            tests++;
            if ({req0_ready, req1_ready, rsp_valid, busy} !== {e_r0, e_r1, e_rv, e_busy}) begin
                fails++; $display("FAIL rand_ctl i=%0d got r0r1/rv/busy=%b%b%b%b exp=%b%b%b%b", i, req0_ready, req1_ready, rsp_valid, busy, e_r0, e_r1, e_rv, e_busy);
            end
            if (!reset) begin
                tests++;
                if ({add_in1, add_in2} !== {m_a, m_b}) begin fails++; $display("FAIL rand_add_in i=%0d got=%h%h exp=%h%h", i, add_in1, add_in2, m_a, m_b); end
            end
            if (e_rv) begin
                tests++;
                if ({rsp_id, rsp_le, rsp_e, rsp_r} !== {m_id, ref_le(m_a, m_b), ref_e(m_a, m_b), ref_r(m_a, m_b)}) begin
                    fails++; $display("FAIL rand_rsp i=%0d got=%b/%h/%h/%h exp=%b/%h/%h/%h", i, rsp_id, rsp_le, rsp_e, rsp_r, m_id, ref_le(m_a, m_b), ref_e(m_a, m_b), ref_r(m_a, m_b));
                end
            end
            if (reset) begin
                m_busy = 0; m_ptr = 0; m_id = 0; m_a = '0; m_b = '0;
            end else if (e_r0 || e_r1) begin
                m_busy = 1; m_ptr = !g; m_id = g;
                m_a = g ? req1_a : req0_a;
                m_b = g ? req1_b : req0_b;
                rsp_from = cyc + 1 + LAT;
            end else if (e_rv && rsp_ready) begin
                m_busy = 0;
            end
            cyc++;
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stub_fixed = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        #1;
        test_reset();
        test_single_hold();
        test_both();
        test_reset_exec();
        test_req1_only();
        test_lat1();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
